// File: rtl/rmii_tx_arbiter_if.sv
// Signal bundle between two frame sources and the RMII TX arbiter.
interface rmii_tx_arbiter_if;
  logic       req0;
  logic       axiiv0;
  logic [1:0] axiid0;
  logic       req1;
  logic       axiiv1;
  logic [1:0] axiid1;
  logic       grant0;
  logic       grant1;
  logic       axiov;
  logic [1:0] axiod;
  logic       timeout;
  logic       abort;

  modport master (
    output req0, axiiv0, axiid0, req1, axiiv1, axiid1,
    input  grant0, grant1, axiov, axiod, timeout, abort
  );

  modport slave (
    input  req0, axiiv0, axiid0, req1, axiiv1, axiid1,
    output grant0, grant1, axiov, axiod, timeout, abort
  );
endinterface

// File: rtl/rmii_tx_arbiter.sv
// Round-robin, whole-frame arbiter for the shared RMII TX dibit path.
// Enforces the inter-frame gap, drops stalled grants and cuts runaway frames.
module rmii_tx_arbiter #(
  parameter int unsigned IFG_DIBITS    = 48,
  parameter int unsigned GRANT_TIMEOUT = 16,
  parameter int unsigned MAX_DIBITS    = 6104
) (
  input  logic              clk,
  input  logic              rst,
  rmii_tx_arbiter_if.slave  bus
);

  localparam int unsigned WAIT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT_WAIT, SEND, GAP} state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                prio_q, prio_d;
  logic                grant0_q, grant0_d;
  logic                grant1_q, grant1_d;
  logic                axiov_q, axiov_d;
  logic [1:0]          axiod_q, axiod_d;
  logic                timeout_q, timeout_d;
  logic                abort_q, abort_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [12:0]         len_q, len_d;
  logic [5:0]          gap_q, gap_d;

  logic                src_v;
  logic [1:0]          src_dat;
  logic                pick;

  // Select the granted source's dibit stream and the IDLE arbitration winner
  always_comb begin
    src_v   = sel_q ? bus.axiiv1 : bus.axiiv0;
    src_dat = sel_q ? bus.axiid1 : bus.axiid0;
    pick    = (bus.req0 && bus.req1) ? prio_q : bus.req1;
  end

  // Next-state and registered-output computation for the arbitration FSM
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    prio_d    = prio_q;
    grant0_d  = grant0_q;
    grant1_d  = grant1_q;
    axiov_d   = 1'b0;
    axiod_d   = '0;
    timeout_d = 1'b0;
    abort_d   = 1'b0;
    wait_d    = wait_q;
    len_d     = len_q;
    gap_d     = gap_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel_d    = pick;
          grant0_d = ~pick;
          grant1_d = pick;
          wait_d   = '0;
          state_d  = GRANT_WAIT;
        end
      end
      GRANT_WAIT: begin
        if (src_v) begin
          axiov_d = 1'b1;
          axiod_d = src_dat;
          len_d   = 13'd1;
          state_d = SEND;
        end else if (wait_q == WAIT_W'(GRANT_TIMEOUT - 1)) begin
          grant0_d  = 1'b0;
          grant1_d  = 1'b0;
          timeout_d = 1'b1;
          prio_d    = ~sel_q;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SEND: begin
        // Valid dropping exactly at the length limit is a normal end, so the
        // end-of-frame test takes precedence over the abort test.
        if (!src_v || (len_q == 13'(MAX_DIBITS))) begin
          grant0_d = 1'b0;
          grant1_d = 1'b0;
          prio_d   = ~sel_q;
          abort_d  = src_v;
          gap_d    = '0;
          state_d  = GAP;
        end else begin
          axiov_d = 1'b1;
          axiod_d = src_dat;
          len_d   = len_q + 13'd1;
        end
      end
      GAP: begin
        if (gap_q == 6'(IFG_DIBITS - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      prio_q    <= 1'b0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      axiov_q   <= 1'b0;
      axiod_q   <= '0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
      wait_q    <= '0;
      len_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      prio_q    <= prio_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      timeout_q <= timeout_d;
      abort_q   <= abort_d;
      wait_q    <= wait_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.grant0  = grant0_q;
  assign bus.grant1  = grant1_q;
  assign bus.axiov   = axiov_q;
  assign bus.axiod   = axiod_q;
  assign bus.timeout = timeout_q;
  assign bus.abort   = abort_q;

endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Testbench for rmii_tx_arbiter: two scripted frame sources, scoreboard of
// forwarded dibits, and per-scenario timing checks.
module tb_rmii_tx_arbiter;

  localparam int unsigned IFG  = 48;
  localparam int unsigned TMO  = 16;
  localparam int unsigned MAXD = 6104;

  logic clk;
  logic rst;

  rmii_tx_arbiter_if bus ();

  rmii_tx_arbiter #(
    .IFG_DIBITS(IFG),
    .GRANT_TIMEOUT(TMO),
    .MAX_DIBITS(MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_pass;

  // Source models
  int unsigned frames_left [2];
  int unsigned cfg_len     [2];
  int unsigned cfg_delay   [2];
  int unsigned phase       [2];
  int unsigned wcnt        [2];
  int unsigned idx         [2];
  bit          hold        [2];
  bit          noise1;
  logic        v0, v1;
  logic [1:0]  d0, d1;

  assign bus.req0   = (frames_left[0] != 0) && (hold[0] || phase[0] == 0);
  assign bus.req1   = (frames_left[1] != 0) && (hold[1] || phase[1] == 0);
  assign bus.axiiv0 = v0;
  assign bus.axiid0 = d0;
  assign bus.axiiv1 = v1;
  assign bus.axiid1 = d1;

  // Scoreboard and monitor state
  logic [1:0]  exp_q [$];
  int unsigned grant_log [$];
  int unsigned grant_cyc [$];
  int unsigned gap_log   [$];
  int unsigned cyc;
  int unsigned ov_run, ov_len_last, ov_rise_cyc;
  int unsigned g_run [2];
  int unsigned g_len_last [2];
  int unsigned gap_run;
  bit          gap_active;
  int unsigned tmo_hi, abort_hi;
  logic        p_ov, pg0, pg1;

  // Frame sources: react to grants one step after the clock edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        logic       g;
        logic       vv;
        logic [1:0] dd;
        g  = (s == 0) ? bus.grant0 : bus.grant1;
        vv = 1'b0;
        dd = 2'b00;
        if (phase[s] == 0 && g && frames_left[s] != 0) begin
          phase[s] = 1;
          wcnt[s]  = cfg_delay[s];
        end
        if (phase[s] == 1) begin
          if (!g) begin
            phase[s] = 0;
            frames_left[s]--;
          end else if (wcnt[s] == 0) begin
            phase[s] = 2;
            idx[s]   = 0;
          end else begin
            wcnt[s]--;
          end
        end
        if (phase[s] == 2) begin
          if (idx[s] < cfg_len[s]) begin
            vv = 1'b1;
            dd = (s == 0) ? 2'(idx[s] % 4) : 2'(3 - (idx[s] % 4));
            if (idx[s] < MAXD) exp_q.push_back(dd);
            idx[s]++;
          end else begin
            phase[s] = 3;
          end
        end
        if (phase[s] == 3 && !g) begin
          phase[s] = 0;
          frames_left[s]--;
        end
        if (s == 1 && phase[1] == 0 && noise1) begin
          vv = 1'($urandom_range(0, 1));
          dd = 2'($urandom_range(0, 3));
        end
        if (s == 0) begin v0 = vv; d0 = dd; end
        else        begin v1 = vv; d1 = dd; end
      end
    end
  end

  // Output monitor: scoreboard pops and per-cycle invariants
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_ov = 1'b0; pg0 = 1'b0; pg1 = 1'b0;
      ov_run = 0; g_run[0] = 0; g_run[1] = 0;
      gap_active = 1'b0;
    end else begin
      n_checks++;
      if ((bus.grant0 & bus.grant1) !== 1'b0) $display("FAIL grant_excl: grant0=%b grant1=%b, required not both", bus.grant0, bus.grant1);
      else n_pass++;
      if (bus.axiov) begin
        if (!p_ov) ov_rise_cyc = cyc;
        ov_run++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL sb_extra: axiod=%0d forwarded, required no dibit", bus.axiod);
        else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (bus.axiod !== e) $display("FAIL sb_data: axiod=%0d, required %0d", bus.axiod, e);
          else n_pass++;
        end
      end else begin
        n_checks++;
        if (bus.axiod !== 2'b00) $display("FAIL axiod_idle: axiod=%0d, required 0", bus.axiod);
        else n_pass++;
        if (p_ov) begin
          ov_len_last = ov_run;
          ov_run      = 0;
          n_checks++;
          if ({bus.grant0, bus.grant1} !== 2'b00) $display("FAIL grant_at_end: grants=%b%b, required 00", bus.grant0, bus.grant1);
          else n_pass++;
          gap_active = 1'b1;
          gap_run    = 0;
        end
      end
      if (gap_active) begin
        if (bus.grant0 || bus.grant1) begin
          gap_log.push_back(gap_run);
          gap_active = 1'b0;
        end else begin
          gap_run++;
        end
      end
      if (bus.grant0) begin
        if (!pg0) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
        g_run[0]++;
      end else if (pg0) begin
        g_len_last[0] = g_run[0]; g_run[0] = 0;
      end
      if (bus.grant1) begin
        if (!pg1) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
        g_run[1]++;
      end else if (pg1) begin
        g_len_last[1] = g_run[1]; g_run[1] = 0;
      end
      tmo_hi   += int'(bus.timeout);
      abort_hi += int'(bus.abort);
      p_ov = bus.axiov; pg0 = bus.grant0; pg1 = bus.grant1;
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    gap_log.delete();
    gap_active = 1'b0;
    tmo_hi     = 0;
    abort_hi   = 0;
  endtask

  task automatic set_src(input int s, input int unsigned frames, input int unsigned len,
                         input int unsigned dly, input bit hld);
    cfg_len[s]     = len;
    cfg_delay[s]   = dly;
    hold[s]        = hld;
    frames_left[s] = frames;
  endtask

  task automatic wait_done(input int unsigned budget, input string name);
    int unsigned k;
    k = 0;
    while (!(frames_left[0] == 0 && frames_left[1] == 0 && phase[0] == 0 && phase[1] == 0 &&
             !bus.grant0 && !bus.grant1 && exp_q.size() == 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (k >= budget) $display("FAIL %s_done: still busy after %0d cycles, required idle", name, k);
    else n_pass++;
    repeat (IFG + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++; if (bus.grant0  !== 1'b0)  $display("FAIL rst_grant0: %b, required 0", bus.grant0);  else n_pass++;
    n_checks++; if (bus.grant1  !== 1'b0)  $display("FAIL rst_grant1: %b, required 0", bus.grant1);  else n_pass++;
    n_checks++; if (bus.axiov   !== 1'b0)  $display("FAIL rst_axiov: %b, required 0", bus.axiov);    else n_pass++;
    n_checks++; if (bus.axiod   !== 2'b00) $display("FAIL rst_axiod: %0d, required 0", bus.axiod);   else n_pass++;
    n_checks++; if (bus.timeout !== 1'b0)  $display("FAIL rst_timeout: %b, required 0", bus.timeout); else n_pass++;
    n_checks++; if (bus.abort   !== 1'b0)  $display("FAIL rst_abort: %b, required 0", bus.abort);    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.grant0, bus.grant1} !== 2'b00) $display("FAIL idle_no_req: grants=%b%b, required 00", bus.grant0, bus.grant1);
    else n_pass++;
  endtask

  // 100 dibits, valid two cycles after grant: grant spans 2 wait + 1 first + 100
  task automatic test_single_frame();
    clear_logs();
    set_src(0, 1, 100, 2, 1'b0);
    wait_done(2000, "single");
    n_checks++; if (ov_len_last !== 100) $display("FAIL single_len: axiov run %0d, required 100", ov_len_last); else n_pass++;
    n_checks++; if (g_len_last[0] !== 103) $display("FAIL single_grant: grant0 run %0d, required 103", g_len_last[0]); else n_pass++;
    n_checks++;
    if (grant_cyc.size() != 1 || ov_rise_cyc - grant_cyc[0] != 3)
      $display("FAIL single_latency: grants=%0d first-valid offset %0d, required 1 and 3", grant_cyc.size(), ov_rise_cyc - grant_cyc[0]);
    else n_pass++;
    n_checks++; if (abort_hi !== 0) $display("FAIL single_abort: %0d pulses, required 0", abort_hi); else n_pass++;
  endtask

  // Source 0 was served last, so with both requesting source 1 goes first
  task automatic test_round_robin();
    int unsigned exp_order [6];
    clear_logs();
    exp_order = '{1, 0, 1, 0, 1, 0};
    set_src(0, 3, 20, 0, 1'b1);
    set_src(1, 3, 20, 0, 1'b1);
    wait_done(3000, "rr");
    n_checks++;
    if (grant_log.size() != 6) $display("FAIL rr_count: %0d grants, required 6", grant_log.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      n_checks++;
      if (grant_log[i] !== exp_order[i]) $display("FAIL rr_order[%0d]: source %0d, required %0d", i, grant_log[i], exp_order[i]);
      else n_pass++;
    end
    n_checks++;
    if (gap_log.size() != 5) $display("FAIL rr_gaps: %0d gaps, required 5", gap_log.size());
    else n_pass++;
    for (int i = 0; i < gap_log.size(); i++) begin
      n_checks++;
      if (gap_log[i] !== IFG + 1) $display("FAIL rr_gap[%0d]: %0d idle cycles, required %0d", i, gap_log[i], IFG + 1);
      else n_pass++;
    end
  endtask

  // Source 1 stalls; after its timeout source 0 is granted on the next edge
  task automatic test_timeout();
    clear_logs();
    set_src(1, 1, 5, 1000, 1'b0);
    set_src(0, 1, 10, 0, 1'b0);
    wait_done(2000, "tmo");
    n_checks++; if (g_len_last[1] !== TMO) $display("FAIL tmo_grant: grant1 run %0d, required %0d", g_len_last[1], TMO); else n_pass++;
    n_checks++; if (tmo_hi !== 1) $display("FAIL tmo_pulse: %0d cycles, required 1", tmo_hi); else n_pass++;
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0)
      $display("FAIL tmo_order: %0d grants first=%0d, required 2 grants 1 then 0", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 9);
    else n_pass++;
    n_checks++;
    if (grant_cyc.size() != 2 || grant_cyc[1] - grant_cyc[0] != TMO + 1)
      $display("FAIL tmo_next: grant spacing %0d, required %0d", grant_cyc.size() == 2 ? grant_cyc[1] - grant_cyc[0] : 0, TMO + 1);
    else n_pass++;
    n_checks++; if (ov_len_last !== 10) $display("FAIL tmo_frame: axiov run %0d, required 10", ov_len_last); else n_pass++;
  endtask

  // Runaway frame on source 0 while source 1 drives noise without requesting
  task automatic test_abort_noise();
    clear_logs();
    noise1 = 1'b1;
    set_src(0, 1, 6200, 0, 1'b0);
    wait_done(20000, "abort");
    noise1 = 1'b0;
    v1 = 1'b0; d1 = 2'b00;
    n_checks++; if (ov_len_last !== MAXD) $display("FAIL abort_len: axiov run %0d, required %0d", ov_len_last, MAXD); else n_pass++;
    n_checks++; if (abort_hi !== 1) $display("FAIL abort_pulse: %0d cycles, required 1", abort_hi); else n_pass++;
    n_checks++; if (g_len_last[0] !== MAXD + 1) $display("FAIL abort_grant: grant0 run %0d, required %0d", g_len_last[0], MAXD + 1); else n_pass++;
    n_checks++; if (grant_log.size() !== 1) $display("FAIL abort_regrant: %0d grants, required 1", grant_log.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    int unsigned k;
    clear_logs();
    set_src(0, 1, 50, 0, 1'b0);
    k = 0;
    while (!bus.axiov && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (k >= 100) $display("FAIL arst_start: axiov never rose, required rise");
    else n_pass++;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.axiov  !== 1'b0)  $display("FAIL arst_axiov: %b, required 0", bus.axiov);  else n_pass++;
    n_checks++; if (bus.axiod  !== 2'b00) $display("FAIL arst_axiod: %0d, required 0", bus.axiod); else n_pass++;
    n_checks++; if (bus.grant0 !== 1'b0)  $display("FAIL arst_grant0: %b, required 0", bus.grant0); else n_pass++;
    frames_left[0] = 0;
    phase[0]       = 0;
    v0 = 1'b0; d0 = 2'b00;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    set_src(1, 1, 8, 0, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.grant0, bus.grant1} !== 2'b01) $display("FAIL arst_regrant: grants=%b%b, required 01", bus.grant0, bus.grant1);
    else n_pass++;
    wait_done(500, "arst");
    n_checks++; if (ov_len_last !== 8) $display("FAIL arst_frame: axiov run %0d, required 8", ov_len_last); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    for (int s = 0; s < 2; s++) begin
      frames_left[s] = 0; cfg_len[s] = 0; cfg_delay[s] = 0;
      phase[s] = 0; wcnt[s] = 0; idx[s] = 0; hold[s] = 1'b0;
      g_run[s] = 0; g_len_last[s] = 0;
    end
    noise1 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = 2'b00; d1 = 2'b00;
    ov_run = 0; ov_len_last = 0; ov_rise_cyc = 0; gap_run = 0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_abort_noise();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rmii_tx_arbiter.md
Name: rmii_tx_arbiter

Overview:
- Shares the single 2-bit RMII transmit dibit path between two frame sources. Each source delivers a complete Ethernet frame, preamble included, as a contiguous run of valid dibits.
- Arbitrates per whole frame using round-robin, enforces the inter-frame gap, and guards against stalled or runaway requesters.
- Sits between the packet sources (e.g. reply generator, forwarder behind the MAC filter) and the RMII TX pins.

Parameters:
- IFG_DIBITS, 48, idle dibit cycles forced between frames (96 bit times).
- GRANT_TIMEOUT, 16, max cycles a granted source may take to raise valid.
- MAX_DIBITS, 6104, max dibits per frame before abort (1526 bytes).

Ports:
- clk  in  1  50 MHz RMII reference clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  source 0 requests a frame slot
- axiiv0  in  1  source 0 dibit valid
- axiid0  in  2  source 0 dibit
- req1  in  1  source 1 requests a frame slot
- axiiv1  in  1  source 1 dibit valid
- axiid1  in  2  source 1 dibit
- grant0  out  1  source 0 owns the path
- grant1  out  1  source 1 owns the path
- axiov  out  1  dibit valid to RMII TX (TX_EN)
- axiod  out  2  dibit to RMII TX (TXD)
- timeout  out  1  one-cycle pulse: granted source never raised valid
- abort  out  1  one-cycle pulse: frame exceeded MAX_DIBITS

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
  - On rst, all outputs go to 0 immediately: grants, axiov, axiod=2'b00, timeout, abort.
  - State returns to IDLE; the round-robin pointer favours source 0; counters clear.
  - Reset mid-frame truncates the frame with no gap enforcement.
- All outputs are registered.
- State IDLE:
  - req is sampled only in IDLE.
  - If one req is high, grant it. If both are high, grant the source not served last (pointer).
  - At the next edge: state goes to GRANT_WAIT, the chosen grant is 1, and the wait counter is 0.
  - No req: stay in IDLE.
- State GRANT_WAIT:
  - If the granted source's axiiv is 1, go to SEND. That dibit appears on axiov/axiod after the edge (1-cycle latency). The length counter becomes 1.
  - Else increment the wait counter. When it reaches GRANT_TIMEOUT-1 without valid: drop the grant, pulse timeout, go to IDLE. The pointer marks this source as served.
  - req changes while granted are ignored.
- State SEND:
  - Each cycle, axiov/axiod take the granted source's axiiv/axiid from the previous cycle.
  - When the granted axiiv is sampled 0: at that edge axiov goes 0, the grant drops, the pointer is updated, and the state goes to GAP.
  - When the length counter reaches MAX_DIBITS with valid still high: at that edge axiov goes 0, the grant drops, abort pulses, the pointer is updated, and the state goes to GAP.
  - After an abort, the offending source's remaining dibits are ignored.
- State GAP:
  - axiov=0 and axiod=0 for exactly IFG_DIBITS cycles, then IDLE.
  - An earlier req waits. The earliest next grant is the cycle after GAP ends.
- Non-granted source: axiiv/axiid are never forwarded. Their activity has no effect.
- Grant exclusivity: grant0 & grant1 is never 1.
- Grant is 1 only in GRANT_WAIT and SEND.
- axiod is 2'b00 whenever axiov=0.
- Counters are sized for the parameters: wait counter clog2(GRANT_TIMEOUT), length counter 13 bits, gap counter 6 bits. None may wrap.
- Valid deassertion in the same cycle as MAX_DIBITS is reached is treated as a normal frame end: no abort.

Test Plan:
- req0 held, source 0 sends 100 valid dibits (pattern 0,1,2,3 repeating) two cycles after grant0 → axiov high for exactly 100 cycles, one cycle delayed, identical dibits; grant0 drops at the frame end; no grant for 48 cycles after axiov falls.
- req0 and req1 both high continuously, 20-dibit frames → grants alternate 0,1,0,1; every inter-frame idle gap is ≥48 cycles; grant0 & grant1 never 1 together.
- req1 high, source 1 never raises axiiv1 → grant1 high for 16 cycles, then timeout pulses once and grant1 drops; source 0 is served next if requesting.
- Source 0 holds valid for 6200 dibits → axiov high for 6104 cycles, then abort pulses, axiov goes 0, and the remaining input is ignored; GAP follows.
- While source 0 is granted and sending, source 1 toggles axiiv1/axiid1 → axiod carries only source 0 data.
- Assert rst asynchronously mid-SEND, between clock edges → axiov, axiod and the grants go 0 before the next edge; after release with req1 alone, grant1 is asserted 1 cycle later with no gap.
